// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, colours, pattern indices and scheduler state.
package vga_pkg;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BACK = 48;
  localparam int VGA_H_VALID = 640;
  localparam int VGA_H_TOTAL = 800;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BACK = 33;
  localparam int VGA_V_VALID = 480;
  localparam int VGA_V_TOTAL = 525;
  localparam int VGA_NUM_PAT = 5;
  localparam int VGA_FRAMES_PER_PAT = 120;
  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_RED = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE = 16'h001F;
  localparam logic [2:0] PAT_BAR = 3'd0;
  localparam logic [2:0] PAT_CHECK = 3'd1;
  localparam logic [2:0] PAT_HGRAD = 3'd2;
  localparam logic [2:0] PAT_SOLID = 3'd3;
  localparam logic [2:0] PAT_BORDER = 3'd4;
  typedef enum logic {S_RUN, S_PEND} sched_state_e;
  function automatic logic [2:0] next_pat(input logic [2:0] p, input int n);
    return ({1'b0, p} == 4'(n - 1)) ? 3'd0 : p + 3'd1;
  endfunction
endpackage

// File: rtl/vga_pat_sched.sv
// vga_pat_sched: applies manual or automatic pattern changes only on frame boundaries.
module vga_pat_sched
  import vga_pkg::*;
#(
  parameter int NUM_PAT = VGA_NUM_PAT,
  parameter int FRAMES_PER_PAT = VGA_FRAMES_PER_PAT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fb_i,
  input  logic       pat_req_i,
  input  logic [2:0] pat_sel_in_i,
  input  logic       auto_en_i,
  output logic [2:0] pat_sel_o,
  output logic       pat_ack_o
);
  localparam int CW = $clog2(FRAMES_PER_PAT + 1);
  sched_state_e state_q;
  logic [2:0] pend_sel_q, pat_sel_q;
  logic [CW-1:0] frame_cnt_q;
  logic pat_ack_q, req_ok, auto_wrap, apply;
  assign req_ok = pat_req_i && ({1'b0, pat_sel_in_i} < 4'(NUM_PAT));
  assign auto_wrap = frame_cnt_q == CW'(FRAMES_PER_PAT - 1);
  assign apply = fb_i && state_q == S_PEND;
  // A manual request pending at the boundary beats the auto step and restarts the frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pend_sel_q <= PAT_BAR;
      pat_sel_q <= PAT_BAR;
      frame_cnt_q <= '0;
      pat_ack_q <= 1'b0;
    end else begin
      pat_ack_q <= apply;
      if (apply) begin
        pat_sel_q <= pend_sel_q;
        frame_cnt_q <= '0;
      end else if (!auto_en_i) begin
        frame_cnt_q <= '0;
      end else if (fb_i) begin
        frame_cnt_q <= auto_wrap ? '0 : frame_cnt_q + 1'b1;
        if (auto_wrap) pat_sel_q <= next_pat(pat_sel_q, NUM_PAT);
      end
      if (req_ok) begin
        pend_sel_q <= pat_sel_in_i;
        state_q <= S_PEND;
      end else if (fb_i) begin
        state_q <= S_RUN;
      end
    end
  end
  assign pat_sel_o = pat_sel_q;
  assign pat_ack_o = pat_ack_q;
endmodule

// File: rtl/vga_ctrl_seq.sv
// vga_ctrl_seq: VGA frame timing, pixel coordinate/RGB re-timing and pattern scheduling.
module vga_ctrl_seq
  import vga_pkg::*;
#(
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BACK = VGA_H_BACK,
  parameter int H_VALID = VGA_H_VALID,
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BACK = VGA_V_BACK,
  parameter int V_VALID = VGA_V_VALID,
  parameter int V_TOTAL = VGA_V_TOTAL,
  parameter int NUM_PAT = VGA_NUM_PAT,
  parameter int FRAMES_PER_PAT = VGA_FRAMES_PER_PAT
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        pat_req,
  input  logic [2:0]  pat_sel_in,
  input  logic        auto_en,
  input  logic [15:0] pix_data_in,
  output logic        hsync,
  output logic        vsync,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_data_req,
  output logic [15:0] rgb,
  output logic [2:0]  pat_sel,
  output logic        pat_ack,
  output logic        frame_start
);
  localparam int HA = H_SYNC + H_BACK;
  localparam int VA = V_SYNC + V_BACK;
  logic [9:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
  logic frame_start_q, h_end, v_end, fb, v_act, h_act, h_req;
  assign h_end = cnt_h_q == 10'(H_TOTAL - 1);
  assign v_end = cnt_v_q == 10'(V_TOTAL - 1);
  assign fb = h_end && v_end;
  always_comb begin
    cnt_h_d = h_end ? 10'd0 : cnt_h_q + 10'd1;
    cnt_v_d = h_end ? (v_end ? 10'd0 : cnt_v_q + 10'd1) : cnt_v_q;
  end
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      frame_start_q <= fb;
    end
  end
  assign v_act = cnt_v_q >= 10'(VA) && cnt_v_q < 10'(VA + V_VALID);
  assign h_act = cnt_h_q >= 10'(HA) && cnt_h_q < 10'(HA + H_VALID);
  // Coordinates lead the active window by one clock to absorb the generator's register stage.
  assign h_req = cnt_h_q >= 10'(HA - 1) && cnt_h_q < 10'(HA + H_VALID - 1);
  assign hsync = cnt_h_q < 10'(H_SYNC);
  assign vsync = cnt_v_q < 10'(V_SYNC);
  assign pix_data_req = v_act && h_req;
  assign pix_x = pix_data_req ? cnt_h_q - 10'(HA - 1) : 10'h3FF;
  assign pix_y = pix_data_req ? cnt_v_q - 10'(VA) : 10'h3FF;
  assign rgb = (v_act && h_act) ? pix_data_in : RGB_BLACK;
  assign frame_start = frame_start_q;
  vga_pat_sched #(.NUM_PAT(NUM_PAT), .FRAMES_PER_PAT(FRAMES_PER_PAT)) u_sched (
    .clk(vga_clk),
    .rst(sys_rst),
    .fb_i(fb),
    .pat_req_i(pat_req),
    .pat_sel_in_i(pat_sel_in),
    .auto_en_i(auto_en),
    .pat_sel_o(pat_sel),
    .pat_ack_o(pat_ack)
  );
endmodule

// File: doc/vga_ctrl_seq.md
# vga_ctrl_seq

Frame-timing and pattern-sequencing controller for the 640x480@60 VGA test-pattern path. It generates hsync/vsync and the pixel coordinates that drive the registered pattern generator. It re-times the generator's 16-bit RGB565 output into the active window. It also schedules which test pattern the generator draws, switching only on frame boundaries, from either a manual request or an automatic frame-count rotation.

## Interface
Parameters:
- H_SYNC, 96 — hsync pulse width, clocks
- H_BACK, 48 — h back porch
- H_VALID, 640 — active pixels per line
- H_TOTAL, 800 — clocks per line
- V_SYNC, 2 — vsync pulse width, lines
- V_BACK, 33 — v back porch
- V_VALID, 480 — active lines
- V_TOTAL, 525 — lines per frame
- NUM_PAT, 5 — number of patterns; legal pat_sel 0..NUM_PAT-1
- FRAMES_PER_PAT, 120 — frames per pattern in auto mode, ≥1

Ports:
- vga_clk  in  1  pixel clock, 25.175 MHz nominal
- sys_rst  in  1  synchronous, active-high reset
- pat_req  in  1  one-cycle request to switch pattern
- pat_sel_in  in  3  requested pattern index, sampled with pat_req
- auto_en  in  1  level; enables automatic rotation
- pix_data_in  in  16  RGB565 from pattern generator, one cycle after pix_x/pix_y
- hsync  out  1  active-high sync pulse
- vsync  out  1  active-high sync pulse
- pix_x  out  10  column to generator; 10'h3FF when pix_data_req=0
- pix_y  out  10  row to generator; 10'h3FF when pix_data_req=0
- pix_data_req  out  1  pix_x/pix_y valid
- rgb  out  16  pixel to DAC; 0 outside active window
- pat_sel  out  3  current pattern index to generator
- pat_ack  out  1  one-cycle pulse: requested pattern applied
- frame_start  out  1  one-cycle pulse on the first clock of each frame

## Operation
- Counters: cnt_h 0..H_TOTAL-1, wraps to 0. cnt_v increments when cnt_h wraps, 0..V_TOTAL-1, wraps to 0.
- hsync = (cnt_h < H_SYNC). vsync = (cnt_v < V_SYNC).
- Active window: cnt_h in [H_SYNC+H_BACK, +H_VALID) = [144,784) and cnt_v in [35,515).
- pix_data_req covers cnt_h in [143,783) on active lines, i.e. one clock early to cover the generator's register stage. pix_x = cnt_h-143. pix_y = cnt_v-35.
- rgb = pix_data_in inside the active window, else 16'h0000.
- Frame boundary (FB): cycle with cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1. pat_sel updates only at FB, so every frame is drawn with one pattern.
- Scheduler FSM, states RUN and PEND:
  - RUN with pat_req and pat_sel_in<NUM_PAT: latch pend_sel, go to PEND.
  - pat_req with pat_sel_in≥NUM_PAT: ignored, no ack.
  - PEND with another valid pat_req: pend_sel overwritten, last request wins.
  - PEND at FB: pat_sel←pend_sel, frame_cnt←0, pat_ack=1 next cycle, go to RUN.
  - pat_req in the FB cycle itself: captured, applied at the next FB.
- Auto rotation: frame_cnt increments at FB while auto_en=1. frame_cnt is held at 0 while auto_en=0. At FB with frame_cnt=FRAMES_PER_PAT-1: pat_sel←(pat_sel+1) mod NUM_PAT, frame_cnt←0, no pat_ack.
- Simultaneous pending manual and auto at one FB: manual wins, auto step discarded, frame_cnt←0.

## Timing
- Reset values, with everything registered cleared to 0 (cnt_h=cnt_v=0, state RUN, frame_cnt=0, pend_sel=0):
  - pat_sel=0, pat_ack=0, frame_start=0.
  - Decoded from counters: hsync=1, vsync=1, pix_data_req=0, pix_x=pix_y=3FF, rgb=0.
- Reset mid-frame: next cycle counters are (0,0), pending request dropped, pat_sel=0. frame_start is not pulsed for the reset-exit frame.
- frame_start and pat_ack are registered. Both are high during the cycle counters read (0,0) after a wrap.
- Generator-to-rgb latency: 1 clock. Request-to-apply latency: until the next FB, at most one frame plus one clock.
- One line = 800 clocks. hsync high for 96 clocks. vsync high for 1600 clocks.

## Structure
- Package vga_pkg holds:
  - timing constants
  - RGB565 colour constants
  - pattern index constants: PAT_BAR=0, PAT_CHECK=1, PAT_HGRAD=2, PAT_SOLID=3, PAT_BORDER=4
  - scheduler state enum
- Sub-module vga_pat_sched: FSM, pend_sel, frame_cnt, pat_sel, pat_ack. Inputs are an fb strobe and the request/auto signals.
- Timing counters and decode live in the top.

## Test plan
- Reset and line timing: release reset → hsync high exactly 96 clocks per 800, pix_data_req first at cnt_h=143 on line 35, 640 clocks wide, pix_x 0..639.
- Latency: generator model returns pix_x in rgb → rgb equals the column at every active pixel, 0 at cnt_h=143 and cnt_h=784.
- Manual switch: pat_req with pat_sel_in=3 mid-frame → pat_sel stays 0 to FB, =3 with pat_ack pulse on the frame_start cycle; requests 2 then 4 in the same frame → only 4 applied, one ack.
- Auto rotation with FRAMES_PER_PAT=2, NUM_PAT=5 → pat_sel 0,0,1,1,2,2,3,3,4,4,0 per frame, no ack.
- Collision and invalid: manual pat_sel_in=1 pending at the FB where auto would step → pat_sel=1, frame_cnt=0; pat_sel_in=6 → ignored, no ack.
- Reset at cnt_v=200 with a request pending → counters (0,0), pat_sel=0, no pat_ack, no frame_start that cycle.
